// File: rtl/bc_mini_slide_unit.sv
// bc_mini_slide_unit
// Lane-0 consumer of the broadcast buffer. Pulls 64-bit words under a
// credit rule (the buffer's valid cannot be back-pressured), lands them in
// a small FIFO and unpacks each word into two fp32 elements, low half
// first. Every element is forked to the local matmul operand port and to
// the slide chain toward lane 1; it retires once both sinks have taken it.
// After the last element of a round the unit drains and pulses invalidate
// so the buffer can flush and swap banks.
//
// Optional build feature: define BC_SLIDE_PERF_CNT_EN to add the saturating
// stall_op_o / stall_slide_o / starve_o performance counters.
//
// MaxBlen mirrors matmul_pkg::MAX_BLEN so this file stays self-contained.
module bc_mini_slide_unit #(
  parameter  int unsigned FifoDepth = 2,
  parameter  int unsigned MaxBlen   = 64,
  localparam int unsigned BlenWidth = $clog2(MaxBlen) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_valid_i,
  input  logic [BlenWidth-1:0] cfg_blen_i,
  output logic                 cfg_ready_o,
  output logic                 bc_data_ready_o,
  input  logic [63:0]          bc_data_i,
  input  logic                 bc_data_valid_i,
  output logic                 bc_data_invalidate_o,
  output logic [31:0]          op_data_o,
  output logic                 op_valid_o,
  input  logic                 op_ready_i,
  output logic [31:0]          slide_data_o,
  output logic                 slide_valid_o,
  input  logic                 slide_ready_i,
  output logic                 round_busy_o
`ifdef BC_SLIDE_PERF_CNT_EN
  ,
  output logic [31:0]          stall_op_o,
  output logic [31:0]          stall_slide_o,
  output logic [31:0]          starve_o
`endif
);

  localparam int unsigned PtrWidth = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntWidth = $clog2(FifoDepth + 1);

  localparam logic [PtrWidth-1:0] PtrLast  = PtrWidth'(FifoDepth - 1);
  localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(FifoDepth);
  localparam logic [CntWidth:0]   DepthExt = {1'b0, DepthCnt};
  localparam logic [BlenWidth-1:0] MaxBlenV = BlenWidth'(MaxBlen);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    INVAL  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Landing FIFO storage and bookkeeping.
  logic [63:0]          fifo_mem_q [FifoDepth];
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]  fifo_count_q, fifo_count_d;

  // Credit and round bookkeeping.
  logic                 inflight_q;
  logic [BlenWidth-1:0] blen_q, blen_d;
  logic [BlenWidth-1:0] words_req_q, words_req_d;
  logic [BlenWidth-1:0] elem_cnt_q, elem_cnt_d;

  // Unpack / fork bookkeeping.
  logic                 half_q, half_d;
  logic                 op_taken_q, op_taken_d;
  logic                 slide_taken_q, slide_taken_d;

  // Derived signals.
  logic                 fifo_empty_s;
  logic                 fifo_full_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 req_s;
  logic                 credit_ok_s;
  logic [BlenWidth-1:0] words_total_s;
  logic [63:0]          head_word_s;
  logic [31:0]          elem_s;
  logic                 op_hs_s;
  logic                 slide_hs_s;
  logic                 op_done_s;
  logic                 slide_done_s;
  logic                 retire_s;
  logic                 elem_last_s;
  logic                 round_start_s;
  logic                 stream_done_s;

  // Wrap a FIFO pointer at FifoDepth, which need not be a power of two.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
    logic [PtrWidth-1:0] nxt;
    if (ptr == PtrLast) begin
      nxt = '0;
    end else begin
      nxt = ptr + PtrWidth'(1);
    end
    return nxt;
  endfunction

  assign fifo_empty_s  = (fifo_count_q == '0);
  assign fifo_full_s   = (fifo_count_q == DepthCnt);
  assign push_s        = bc_data_valid_i && !fifo_full_s;

  // W = ceil(blen / 2), computed one bit wider so blen = MaxBlen cannot wrap.
  assign words_total_s = BlenWidth'(({1'b0, blen_q} + {{BlenWidth{1'b0}}, 1'b1}) >> 1);

  // A word is owed to us for every request of the previous cycle, so those
  // count against FIFO space exactly like words already landed.
  assign credit_ok_s   = ({1'b0, fifo_count_q} + {{CntWidth{1'b0}}, inflight_q}) < DepthExt;
  assign req_s         = (state_q == STREAM) && (words_req_q < words_total_s) && credit_ok_s;

  assign head_word_s   = fifo_mem_q[rd_ptr_q];
  assign elem_s        = half_q ? head_word_s[63:32] : head_word_s[31:0];

  assign op_valid_o    = !fifo_empty_s && !op_taken_q;
  assign slide_valid_o = !fifo_empty_s && !slide_taken_q;
  assign op_data_o     = elem_s;
  assign slide_data_o  = elem_s;

  assign op_hs_s       = op_valid_o && op_ready_i;
  assign slide_hs_s    = slide_valid_o && slide_ready_i;
  assign op_done_s     = op_taken_q || op_hs_s;
  assign slide_done_s  = slide_taken_q || slide_hs_s;
  assign retire_s      = !fifo_empty_s && op_done_s && slide_done_s;

  // The low half of the final word is the last element for odd blen, in
  // which case the unused high half is dropped together with the word.
  assign elem_last_s   = ((elem_cnt_q + BlenWidth'(1)) == blen_q);
  assign pop_s         = retire_s && (half_q || elem_last_s);

  assign round_start_s = (state_q == IDLE) && cfg_valid_i;
  assign stream_done_s = (elem_cnt_q == blen_q) || (retire_s && elem_last_s);

  assign cfg_ready_o          = (state_q == IDLE);
  assign bc_data_ready_o      = req_s;
  assign bc_data_invalidate_o = (state_q == INVAL);
  assign round_busy_o         = (state_q != IDLE);

  // Round sequencing: IDLE -> STREAM -> DRAIN -> INVAL -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          state_d = STREAM;
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (stream_done_s) begin
          state_d = DRAIN;
        end else begin
          state_d = STREAM;
        end
      end
      DRAIN: begin
        if (fifo_empty_s && !inflight_q) begin
          state_d = INVAL;
        end else begin
          state_d = DRAIN;
        end
      end
      INVAL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state for FIFO pointers, counters, half-select and fork flags.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_count_d  = fifo_count_q;
    blen_d        = blen_q;
    words_req_d   = words_req_q;
    elem_cnt_d    = elem_cnt_q;
    half_d        = half_q;
    op_taken_d    = op_taken_q;
    slide_taken_d = slide_taken_q;

    if (push_s) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   fifo_count_d = fifo_count_q + CntWidth'(1);
      2'b01:   fifo_count_d = fifo_count_q - CntWidth'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

    if (round_start_s) begin
      blen_d      = cfg_blen_i;
      words_req_d = '0;
      elem_cnt_d  = '0;
    end else begin
      blen_d = blen_q;
      if (req_s) begin
        words_req_d = words_req_q + BlenWidth'(1);
      end else begin
        words_req_d = words_req_q;
      end
      if (retire_s) begin
        elem_cnt_d = elem_cnt_q + BlenWidth'(1);
      end else begin
        elem_cnt_d = elem_cnt_q;
      end
    end

    if (round_start_s || pop_s) begin
      half_d = 1'b0;
    end else if (retire_s) begin
      half_d = 1'b1;
    end else begin
      half_d = half_q;
    end

    // Both flags clear together when the element retires.
    if (retire_s) begin
      op_taken_d    = 1'b0;
      slide_taken_d = 1'b0;
    end else begin
      op_taken_d    = op_taken_q || op_hs_s;
      slide_taken_d = slide_taken_q || slide_hs_s;
    end
  end

  // Datapath registers; words arriving into a full FIFO are discarded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(FifoDepth); i++) begin
        fifo_mem_q[i] <= 64'd0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_count_q  <= '0;
      inflight_q    <= 1'b0;
      blen_q        <= '0;
      words_req_q   <= '0;
      elem_cnt_q    <= '0;
      half_q        <= 1'b0;
      op_taken_q    <= 1'b0;
      slide_taken_q <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_mem_q[wr_ptr_q] <= bc_data_i;
      end
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_count_q  <= fifo_count_d;
      inflight_q    <= req_s;
      blen_q        <= blen_d;
      words_req_q   <= words_req_d;
      elem_cnt_q    <= elem_cnt_d;
      half_q        <= half_d;
      op_taken_q    <= op_taken_d;
      slide_taken_q <= slide_taken_d;
    end
  end

`ifdef BC_SLIDE_PERF_CNT_EN
  logic [31:0] stall_op_q, stall_op_d;
  logic [31:0] stall_slide_q, stall_slide_d;
  logic [31:0] starve_q, starve_d;

  // Saturating increment for the performance counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    logic [31:0] r;
    if (v == 32'hFFFF_FFFF) begin
      r = v;
    end else begin
      r = v + 32'd1;
    end
    return r;
  endfunction

  // Counter next-state: clear on round start, otherwise count stall/starve cycles.
  always_comb begin
    stall_op_d    = stall_op_q;
    stall_slide_d = stall_slide_q;
    starve_d      = starve_q;
    if (round_start_s) begin
      stall_op_d    = 32'd0;
      stall_slide_d = 32'd0;
      starve_d      = 32'd0;
    end else begin
      if (!fifo_empty_s && op_valid_o && !op_ready_i) begin
        stall_op_d = sat_inc(stall_op_q);
      end else begin
        stall_op_d = stall_op_q;
      end
      if (!fifo_empty_s && slide_valid_o && !slide_ready_i) begin
        stall_slide_d = sat_inc(stall_slide_q);
      end else begin
        stall_slide_d = stall_slide_q;
      end
      if ((state_q == STREAM) && fifo_empty_s) begin
        starve_d = sat_inc(starve_q);
      end else begin
        starve_d = starve_q;
      end
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_op_q    <= 32'd0;
      stall_slide_q <= 32'd0;
      starve_q      <= 32'd0;
    end else begin
      stall_op_q    <= stall_op_d;
      stall_slide_q <= stall_slide_d;
      starve_q      <= starve_d;
    end
  end

  assign stall_op_o    = stall_op_q;
  assign stall_slide_o = stall_slide_q;
  assign starve_o      = starve_q;
`endif

  // Upstream must respect the credit rule, and a round may not exceed MaxBlen.
  a_no_push_when_full : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bc_data_valid_i && fifo_full_s));
  a_blen_in_range : assert property (@(posedge clk_i) disable iff (!rst_ni)
    round_start_s |-> (cfg_blen_i <= MaxBlenV));

endmodule

// File: tb/tb_bc_mini_slide_unit.sv
// Testbench for bc_mini_slide_unit: directed and randomized rounds against
// a reference that derives the element stream from the word list and checks
// ordering, request counts, credit limits and invalidate timing.
module tb_bc_mini_slide_unit;
  localparam int MaxBlen   = 64;
  localparam int BlenWidth = $clog2(MaxBlen) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 cfg_valid_i;
  logic [BlenWidth-1:0] cfg_blen_i;
  logic                 cfg_ready_o;
  logic                 bc_data_ready_o;
  logic [63:0]          bc_data_i;
  logic                 bc_data_valid_i;
  logic                 bc_data_invalidate_o;
  logic [31:0]          op_data_o;
  logic                 op_valid_o;
  logic                 op_ready_i;
  logic [31:0]          slide_data_o;
  logic                 slide_valid_o;
  logic                 slide_ready_i;
  logic                 round_busy_o;
`ifdef BC_SLIDE_PERF_CNT_EN
  logic [31:0]          stall_op_o;
  logic [31:0]          stall_slide_o;
  logic [31:0]          starve_o;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  bc_mini_slide_unit #(.FifoDepth(2), .MaxBlen(MaxBlen)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .cfg_valid_i         (cfg_valid_i),
    .cfg_blen_i          (cfg_blen_i),
    .cfg_ready_o         (cfg_ready_o),
    .bc_data_ready_o     (bc_data_ready_o),
    .bc_data_i           (bc_data_i),
    .bc_data_valid_i     (bc_data_valid_i),
    .bc_data_invalidate_o(bc_data_invalidate_o),
    .op_data_o           (op_data_o),
    .op_valid_o          (op_valid_o),
    .op_ready_i          (op_ready_i),
    .slide_data_o        (slide_data_o),
    .slide_valid_o       (slide_valid_o),
    .slide_ready_i       (slide_ready_i),
    .round_busy_o        (round_busy_o)
`ifdef BC_SLIDE_PERF_CNT_EN
    ,
    .stall_op_o          (stall_op_o),
    .stall_slide_o       (stall_slide_o),
    .starve_o            (starve_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_cfg_ready"}, cfg_ready_o, 1);
    check({pfx, "_bc_ready"}, bc_data_ready_o, 0);
    check({pfx, "_inval"}, bc_data_invalidate_o, 0);
    check({pfx, "_op_valid"}, op_valid_o, 0);
    check({pfx, "_op_data"}, op_data_o, 0);
    check({pfx, "_slide_valid"}, slide_valid_o, 0);
    check({pfx, "_slide_data"}, slide_data_o, 0);
    check({pfx, "_busy"}, round_busy_o, 0);
  endtask

  function automatic logic ready_pattern(input int mode, input int cyc);
    logic r;
    case (mode)
      0:       r = 1'b1;
      1:       r = 1'($urandom_range(0, 1));
      default: r = (cyc % 4 == 0);
    endcase
    return r;
  endfunction

  // One round. Ready modes: 0 always, 1 random, 2 one cycle in four.
  // pre_armed: acceptance already happens at the coming posedge.
  // hold_next >= 0: keep cfg_valid_i high with that blen during the round.
  // abort_after >= 0: return once that many elements have retired.
  task automatic run_round(input int blen, input int op_mode, input int sl_mode,
                           input bit patterned, input bit pre_armed,
                           input int hold_next, input int abort_after);
    logic [63:0] words[$];
    logic [31:0] exp_e[$];
    logic [63:0] pend_word;
    bit          pend;
    bit          done;
    int n_words, op_idx, sl_idx, req, retired, last_ret, inval_cnt, cyc, popped, budget;
    int op_first, op_last, mn;

    n_words = (blen + 1) / 2;
    for (int i = 0; i < n_words; i++) begin
      logic [63:0] w;
      if (patterned) w = {32'(2 * i + 2), 32'(2 * i + 1)};
      else           w = {$urandom, $urandom};
      words.push_back(w);
    end
    for (int i = 0; i < blen; i++) begin
      if (i % 2 == 1) exp_e.push_back(words[i / 2][63:32]);
      else            exp_e.push_back(words[i / 2][31:0]);
    end

    if (!pre_armed) begin
      @(negedge clk);
      cfg_valid_i = 1'b1;
      cfg_blen_i  = BlenWidth'(blen);
      check("cfg_ready_idle", cfg_ready_o, 1);
    end

    pend = 1'b0; pend_word = 64'd0; done = 1'b0;
    op_idx = 0; sl_idx = 0; req = 0; retired = 0; last_ret = 0; inval_cnt = 0;
    cyc = 0; op_first = -1; op_last = -1;
    budget = 16 * blen + 40;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        if (hold_next >= 0) cfg_blen_i = BlenWidth'(hold_next);
        else                cfg_valid_i = 1'b0;
      end
      op_ready_i      = ready_pattern(op_mode, cyc);
      slide_ready_i   = ready_pattern(sl_mode, cyc);
      bc_data_valid_i = pend;
      bc_data_i       = pend ? pend_word : {$urandom, $urandom};
      pend            = 1'b0;

      check("busy_in_round", round_busy_o, 1);
      check("cfg_ready_in_round", cfg_ready_o, 0);

      popped = (retired >= blen) ? n_words : retired / 2;
      if (bc_data_ready_o) begin
        check("req_limit", req < n_words, 1);
        check("req_credit", (req - popped) < 2, 1);
        if (req < n_words) pend_word = words[req];
        pend = 1'b1;
        req++;
      end

      if (op_valid_o && op_ready_i) begin
        check("op_overrun", op_idx < blen, 1);
        if (op_idx < blen) check("op_data", op_data_o, exp_e[op_idx]);
        if (op_first < 0) op_first = cyc;
        op_last = cyc;
        op_idx++;
      end
      if (slide_valid_o && slide_ready_i) begin
        check("slide_overrun", sl_idx < blen, 1);
        if (sl_idx < blen) check("slide_data", slide_data_o, exp_e[sl_idx]);
        sl_idx++;
      end
      mn = (op_idx < sl_idx) ? op_idx : sl_idx;
      if (mn != retired) begin
        retired  = mn;
        last_ret = cyc;
      end

      if (bc_data_invalidate_o) begin
        inval_cnt++;
        check("inval_timing", cyc, (blen == 0) ? 3 : last_ret + 2);
        done = 1'b1;
      end
      if (abort_after >= 0 && retired >= abort_after) done = 1'b1;
    end
    if (!done) check("round_timeout", 0, 1);

    if (abort_after < 0) begin
      @(negedge clk);
      bc_data_valid_i = 1'b0;
      check("inval_one_cycle", bc_data_invalidate_o, 0);
      check("busy_after", round_busy_o, 0);
      check("cfg_ready_after", cfg_ready_o, 1);
      check("op_count", op_idx, blen);
      check("slide_count", sl_idx, blen);
      check("req_count", req, n_words);
      check("inval_count", inval_cnt, 1);
      if (op_mode == 0 && sl_mode == 0 && blen > 0)
        check("throughput", op_last - op_first, blen - 1);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    cfg_valid_i     = 1'b0;
    cfg_blen_i      = '0;
    bc_data_i       = 64'd0;
    bc_data_valid_i = 1'b0;
    op_ready_i      = 1'b1;
    slide_ready_i   = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    // Single round, words {2,1}..{8,7}, both sinks ready.
    run_round(8, 0, 0, 1'b1, 1'b0, -1, -1);
    // Odd length: high half of the third word never presented.
    run_round(5, 0, 0, 1'b1, 1'b0, -1, -1);
    // Skewed sinks: slide accepts one cycle in four.
    run_round(4, 0, 2, 1'b1, 1'b0, -1, -1);
    // Back-to-back rounds with cfg_valid_i held high.
    run_round(2, 0, 0, 1'b1, 1'b0, 4, -1);
    run_round(4, 0, 0, 1'b0, 1'b1, -1, -1);
    cfg_valid_i = 1'b0;

    // Asynchronous reset after 3 of 8 elements.
    run_round(8, 0, 0, 1'b1, 1'b0, -1, 3);
    #2;
    rst_n = 1'b0;
    cfg_valid_i     = 1'b0;
    bc_data_valid_i = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_round(2, 0, 0, 1'b0, 1'b0, -1, -1);

    // Zero-length round.
    run_round(0, 0, 0, 1'b0, 1'b0, -1, -1);

    // Boundaries and randomized rounds.
    run_round(1, 1, 1, 1'b0, 1'b0, -1, -1);
    run_round(MaxBlen, 1, 1, 1'b0, 1'b0, -1, -1);
    for (int r = 0; r < 6; r++) begin
      run_round($urandom_range(1, MaxBlen), $urandom_range(0, 2), $urandom_range(0, 2),
                1'b0, 1'b0, -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/bc_mini_slide_unit.md
Name: bc_mini_slide_unit

Overview:
- Lane-0 consumer of the broadcast buffer. Requests 64-bit words from the buffer and unpacks each into two fp32 elements, low half first.
- Forks every element to two sinks: the local lane's matmul operand port and the slide chain toward lane 1.
- Counts elements against the configured broadcast length. At the end of each round it pulses invalidate so the buffer flushes and swaps banks.

Parameters:
- FifoDepth, 2, number of 64-bit word slots in the internal landing FIFO (≥2).
- BlenWidth, $clog2(MAX_BLEN)+1, width of element-count fields (localparam; MAX_BLEN comes from matmul_pkg).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cfg_valid_i  in  1  start-round request
- cfg_blen_i  in  BlenWidth  round length in fp32 elements, 1..MAX_BLEN
- cfg_ready_o  out  1  high in IDLE only
- bc_data_ready_o  out  1  word request to buffer
- bc_data_i  in  64  word from buffer (elen_t)
- bc_data_valid_i  in  1  word valid, arrives exactly 1 cycle after an accepted request
- bc_data_invalidate_o  out  1  one-cycle end-of-round pulse
- op_data_o  out  32  fp32 to local lane
- op_valid_o  out  1
- op_ready_i  in  1
- slide_data_o  out  32  fp32 to next lane
- slide_valid_o  out  1
- slide_ready_i  in  1
- round_busy_o  out  1  high from round start until the invalidate pulse, inclusive

Behaviour:
- Reset values:
  - All outputs 0, except cfg_ready_o = 1.
  - FSM = IDLE; FIFO empty; all counters 0.
- Words per round: W = ceil(blen/2).
- Credit request rule:
  - bc_data_ready_o = (state==STREAM) && (words_req < W) && (fifo_count + inflight < FifoDepth).
  - inflight is a 1-bit register equal to the previous cycle's bc_data_ready_o. The upstream valid is registered and cannot be back-pressured, so this credit rule is mandatory.
  - words_req increments on every cycle bc_data_ready_o is high.
- Landing FIFO:
  - Pushes whenever bc_data_valid_i is high, whatever the state.
  - A valid arriving while the FIFO is full is a protocol error: assertion fires and the word is dropped.
- Unpack:
  - Head word is emitted as element [31:0], then element [63:32]. A half-select bit tracks which half is current.
  - The word pops when its high half retires, or after its low half retires if that low half is element blen-1 (odd blen; the high half is discarded).
- Fork:
  - op_valid_o = slide_valid_o = FIFO non-empty, each masked by its own "already taken" flag. Both data outputs carry the same element.
  - Each flag sets on its sink's handshake. The element retires when both sinks have accepted, possibly in different cycles; both flags then clear in the same cycle.
  - An output's data stays stable while its valid is high.
- elem_cnt increments on each retirement.
- FSM:
  - IDLE: on cfg_valid_i, latch blen, clear counters, go to STREAM. round_busy_o rises the next cycle.
  - STREAM: when elem_cnt reaches blen (the last retirement cycle), go to DRAIN.
  - DRAIN: wait until the FIFO is empty and inflight is 0 (guaranteed by credit accounting), then go to INVAL.
  - INVAL: bc_data_invalidate_o = 1 for exactly one cycle, then go to IDLE.
- Latency: the first element is visible on op/slide two cycles after cfg_valid_i is accepted (request, then data). Throughput is 1 element/cycle with both sinks ready and FifoDepth ≥ 2.
- Boundary conditions:
  - cfg_valid_i outside IDLE is ignored.
  - cfg_blen_i = 0 behaves as a zero-length round: STREAM → DRAIN → INVAL with no requests issued.
  - cfg_blen_i > MAX_BLEN: assertion fires; behaviour undefined.
  - Asynchronous reset mid-round returns to the reset values immediately. Any word still in flight is discarded, because the upstream buffer is reset by the same rst_ni.

Optional Feature:
- Macro: BC_SLIDE_PERF_CNT_EN.
- When defined:
  - Adds 32-bit outputs stall_op_o and stall_slide_o. Each counts cycles where the FIFO is non-empty and its sink's valid is high but ready is low.
  - Adds 32-bit output starve_o, counting STREAM cycles where the FIFO is empty.
  - All three saturate, reset to 0, and clear on round start.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single round, cfg_blen=8, words 0x00000002_00000001 … 0x00000008_00000007, both sinks always ready → op and slide each see 1..8 in consecutive cycles; exactly 4 requests; invalidate pulses once, 1 cycle after DRAIN; cfg_ready_o returns to 1.
- Odd length, cfg_blen=5, words {2,1},{4,3},{6,5} → 3 requests; outputs 1..5; element 6 never presented.
- Skewed sinks, cfg_blen=4, slide_ready_i low for 3 cycles per element → op accepts each element once (no duplicates); the next element waits for slide; bc_data_ready_o never high while FIFO count + inflight = 2.
- Back-to-back rounds, blen=2 then blen=4 with cfg_valid_i held high → second round starts only after the invalidate pulse; the element sequences do not intermix.
- Reset asserted mid-round, after 3 of 8 elements → all outputs return to reset values asynchronously; a following blen=2 round completes normally.
- Zero length, cfg_blen=0 → no bc_data_ready_o; invalidate pulse on the third cycle after acceptance.
